command_tx_arbiter: RTL and testbench
=====================================

COMMAND_TX_ARBITER -- requirements
Module: command_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters; fixed at 4 for this release.
REQ-002 Parameter: TIMEOUT_CYCLES, 32'd200000, clk cycles allowed from command_tx_ready to command_tx_over.
REQ-003 clk  input  1  system clock, rising-edge active; one clock; reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  4  per-requester command pending; held until req_grant.
REQ-006 req_cmd  input  32  four 8-bit command codes; bits [8i+7:8i] belong to requester i.
REQ-007 req_data  input  128  four 32-bit data fields; bits [32i+31:32i] belong to requester i.
REQ-008 req_grant  output  4  one-hot one-cycle pulse: requester's command accepted.
REQ-009 req_done  output  4  one-hot one-cycle pulse: granted command finished transmitting.
REQ-010 req_err  output  4  one-hot one-cycle pulse: granted command timed out.
REQ-011 command_tx_ready  output  1  one-cycle pulse to the command transmitter.
REQ-012 command_tx  output  8  latched command code.
REQ-013 data_field_tx  output  32  latched data field.
REQ-014 command_tx_over  input  1  transmitter completion pulse.
REQ-015 command_tx_status  input  1  transmitter busy level.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 last_grant  output  2  index of most recently granted requester.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_OVER; all outputs registered.
REQ-019 IDLE->ISSUE when (req_valid != 0) and command_tx_status == 0; otherwise remain IDLE.
REQ-020 Selection: round-robin, search starts at last_grant+1 (mod 4), first set req_valid bit wins.
REQ-021 On IDLE->ISSUE edge: latch winner's cmd/data into command_tx/data_field_tx, pulse req_grant[winner], set last_grant=winner.
REQ-022 ISSUE lasts exactly one cycle with command_tx_ready=1, then goes to WAIT_OVER; latency valid-sampled -> grant = 1 cycle, -> command_tx_ready = 2 cycles.
REQ-023 WAIT_OVER: 32-bit timeout counter cleared on entry, increments each cycle.
REQ-024 command_tx_over in WAIT_OVER -> req_done[owner] pulse, go IDLE.
REQ-025 Counter reaching TIMEOUT_CYCLES-1 without command_tx_over -> req_err[owner] pulse, go IDLE.
REQ-026 command_tx_over and timeout terminal in same cycle: done wins, no err.
REQ-027 command_tx_over in IDLE or ISSUE: ignored, no pulses.
REQ-028 req_valid dropped before grant: no grant, no side effects; req_valid changes after grant ignored until next IDLE.
REQ-029 command_tx/data_field_tx hold value until next grant.
REQ-030 Back-to-back: requester re-asserting valid in the cycle after done is eligible; minimum gap done->next command_tx_ready = 2 cycles.

Reset
REQ-031 rst_n low asynchronously forces IDLE, all pulse outputs 0, command_tx=8'd0, data_field_tx=32'd0, busy=0, last_grant=2'd3 (requester 0 first), counter 0.
REQ-032 Reset mid-transaction abandons it; no done/err pulse issued for the abandoned command.

Structure
REQ-033 State encoding, N_REQ and default TIMEOUT_CYCLES constants reside in the shared package with the existing uart defines.
REQ-034 Round-robin selection is one combinational sub-module rr_select_4 (inputs req, last; outputs hit, index).

Verification
REQ-035 Reset, req_valid=4'b0001, cmd 8'h01, data 32'h02030405 -> grant[0] next cycle, command_tx_ready cycle after, command_tx=8'h01, data=32'h02030405; over pulse -> done[0].
REQ-036 req_valid=4'b1111 held, transmitter answers each after 10 cycles -> grant order 0,1,2,3,0.
REQ-037 last_grant=1, req_valid=4'b0011 -> grant[0]; then 4'b0010 only -> grant[1].
REQ-038 TIMEOUT_CYCLES=20, no over -> err[owner] exactly 20 cycles after WAIT_OVER entry, busy drops next cycle.
REQ-039 Over coincident with timeout terminal -> done pulse, err stays 0; command_tx_status=1 in IDLE with valid -> no grant until status falls.
REQ-040 rst_n low during WAIT_OVER -> outputs at reset values immediately, no done/err after release.

Source files
------------

// File: rtl/command_tx_arbiter_pkg.sv
// Shared definitions for the command transmitter arbiter: FSM state encoding,
// requester count and default transmit timeout.
package command_tx_arbiter_pkg;

  localparam int          CTA_N_REQ          = 4;
  localparam logic [31:0] CTA_TIMEOUT_CYCLES = 32'd200000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_OVER = 2'd2
  } cta_state_e;

  // Convert a requester index into its one-hot pulse vector.
  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/command_tx_arbiter_rr.sv
// Round-robin requester selection: the search begins one past the last
// granted requester and wraps modulo 4; the first pending requester wins.
module rr_select_4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       hit,
  output logic [1:0] index
);

  // Scan offsets 1..4 from the last grant; offset 4 wraps back to last itself.
  always_comb begin
    hit   = 1'b0;
    index = last;
    for (int k = 1; k <= 4; k++) begin
      if (!hit && req[last + 2'(k)]) begin
        hit   = 1'b1;
        index = last + 2'(k);
      end
    end
  end

endmodule

// File: rtl/command_tx_arbiter.sv
// Arbitrates four command requesters onto a single command transmitter.
// A winner is latched in IDLE, the transmitter gets a one-cycle ready pulse,
// then the arbiter waits for completion or a timeout and reports the outcome
// to the owning requester. Every output comes straight from a register.
module command_tx_arbiter
  import command_tx_arbiter_pkg::*;
#(
  parameter int          N_REQ          = CTA_N_REQ,
  parameter logic [31:0] TIMEOUT_CYCLES = CTA_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_cmd,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_grant,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_err,
  output logic                 command_tx_ready,
  output logic [7:0]           command_tx,
  output logic [31:0]          data_field_tx,
  input  logic                 command_tx_over,
  input  logic                 command_tx_status,
  output logic                 busy,
  output logic [1:0]           last_grant
);

  cta_state_e  r_state, w_state_nxt;
  logic [3:0]  r_grant, w_grant_nxt;
  logic [3:0]  r_done,  w_done_nxt;
  logic [3:0]  r_err,   w_err_nxt;
  logic        r_ready, w_ready_nxt;
  logic [7:0]  r_cmd,   w_cmd_nxt;
  logic [31:0] r_data,  w_data_nxt;
  logic [1:0]  r_last,  w_last_nxt;
  logic [31:0] r_cnt,   w_cnt_nxt;
  logic        r_busy;
  logic        w_hit;
  logic [1:0]  w_idx;

  rr_select_4 u_rr (
    .req   (req_valid),
    .last  (r_last),
    .hit   (w_hit),
    .index (w_idx)
  );

  // Next-state and next-output logic; pulses default low every cycle and
  // the latched command/data/owner hold unless a new grant happens.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = 4'b0000;
    w_done_nxt  = 4'b0000;
    w_err_nxt   = 4'b0000;
    w_ready_nxt = 1'b0;
    w_cmd_nxt   = r_cmd;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // A busy transmitter blocks new grants; completion pulses are ignored.
        if (w_hit && !command_tx_status) begin
          w_state_nxt = ST_ISSUE;
          w_grant_nxt = idx_to_onehot(w_idx);
          w_last_nxt  = w_idx;
          for (int i = 0; i < 4; i++) begin
            if (w_idx == 2'(i)) begin
              w_cmd_nxt  = req_cmd[8*i +: 8];
              w_data_nxt = req_data[32*i +: 32];
            end
          end
        end
      end
      ST_ISSUE: begin
        // Ready appears together with WAIT_OVER entry, where the timer starts at 0.
        w_state_nxt = ST_WAIT_OVER;
        w_ready_nxt = 1'b1;
        w_cnt_nxt   = 32'd0;
      end
      ST_WAIT_OVER: begin
        // Completion has priority over a timeout landing in the same cycle.
        if (command_tx_over) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = idx_to_onehot(r_last);
          w_cnt_nxt   = 32'd0;
        end else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = idx_to_onehot(r_last);
          w_cnt_nxt   = 32'd0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 4'b0000;
      r_done  <= 4'b0000;
      r_err   <= 4'b0000;
      r_ready <= 1'b0;
      r_cmd   <= 8'd0;
      r_data  <= 32'd0;
      r_last  <= 2'd3;
      r_cnt   <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_ready <= w_ready_nxt;
      r_cmd   <= w_cmd_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign req_grant        = r_grant;
  assign req_done         = r_done;
  assign req_err          = r_err;
  assign command_tx_ready = r_ready;
  assign command_tx       = r_cmd;
  assign data_field_tx    = r_data;
  assign busy             = r_busy;
  assign last_grant       = r_last;

endmodule

// File: tb/tb_command_tx_arbiter.sv
// Directed bench for command_tx_arbiter: a per-cycle vector table followed by
// hand-written round-robin, timeout, coincident-completion and reset sequences.
module tb_command_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [31:0]  req_cmd;
  logic [127:0] req_data;
  logic [3:0]   req_grant;
  logic [3:0]   req_done;
  logic [3:0]   req_err;
  logic         command_tx_ready;
  logic [7:0]   command_tx;
  logic [31:0]  data_field_tx;
  logic         command_tx_over;
  logic         command_tx_status;
  logic         busy;
  logic [1:0]   last_grant;

  int errors = 0;
  int checks = 0;

  command_tx_arbiter #(
    .N_REQ          (4),
    .TIMEOUT_CYCLES (32'd20)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_cmd           (req_cmd),
    .req_data          (req_data),
    .req_grant         (req_grant),
    .req_done          (req_done),
    .req_err           (req_err),
    .command_tx_ready  (command_tx_ready),
    .command_tx        (command_tx),
    .data_field_tx     (data_field_tx),
    .command_tx_over   (command_tx_over),
    .command_tx_status (command_tx_status),
    .busy              (busy),
    .last_grant        (last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        over;
    logic        status;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        ready;
    logic        busy;
    logic [1:0]  last;
    logic [7:0]  cmd;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs[21];
  logic [7:0]  cmds[4];
  logic [31:0] datas[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic o, input logic s,
                              input logic [3:0] g, input logic [3:0] d, input logic r,
                              input logic b, input logic [1:0] l, input logic [7:0] c,
                              input logic [31:0] dt);
    vec_t x;
    x.valid = v; x.over = o; x.status = s; x.grant = g; x.done = d;
    x.ready = r; x.busy = b; x.last = l; x.cmd = c; x.data = dt;
    return x;
  endfunction

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [3:0] exp_g;
    logic       found;
    logic       bad;

    cmds[0] = 8'h01; cmds[1] = 8'h11; cmds[2] = 8'h22; cmds[3] = 8'h33;
    datas[0] = 32'h02030405; datas[1] = 32'hBBBB0001;
    datas[2] = 32'hCCCC0002; datas[3] = 32'hDDDD0003;

    //            valid  ov st  grant  done   rdy bsy last cmd    data
    vecs[0]  = mk(4'h1, 0, 0, 4'h1, 4'h0, 0, 1, 2'd0, 8'h01, 32'h02030405);
    vecs[1]  = mk(4'h0, 1, 0, 4'h0, 4'h0, 1, 1, 2'd0, 8'h01, 32'h02030405);
    vecs[2]  = mk(4'h0, 0, 0, 4'h0, 4'h0, 0, 1, 2'd0, 8'h01, 32'h02030405);
    vecs[3]  = mk(4'h0, 1, 0, 4'h0, 4'h1, 0, 0, 2'd0, 8'h01, 32'h02030405);
    vecs[4]  = mk(4'h0, 1, 0, 4'h0, 4'h0, 0, 0, 2'd0, 8'h01, 32'h02030405);
    vecs[5]  = mk(4'h2, 0, 1, 4'h0, 4'h0, 0, 0, 2'd0, 8'h01, 32'h02030405);
    vecs[6]  = mk(4'h2, 0, 1, 4'h0, 4'h0, 0, 0, 2'd0, 8'h01, 32'h02030405);
    vecs[7]  = mk(4'h2, 0, 0, 4'h2, 4'h0, 0, 1, 2'd1, 8'h11, 32'hBBBB0001);
    vecs[8]  = mk(4'h0, 0, 0, 4'h0, 4'h0, 1, 1, 2'd1, 8'h11, 32'hBBBB0001);
    vecs[9]  = mk(4'h0, 1, 0, 4'h0, 4'h2, 0, 0, 2'd1, 8'h11, 32'hBBBB0001);
    vecs[10] = mk(4'h3, 0, 0, 4'h1, 4'h0, 0, 1, 2'd0, 8'h01, 32'h02030405);
    vecs[11] = mk(4'h2, 0, 0, 4'h0, 4'h0, 1, 1, 2'd0, 8'h01, 32'h02030405);
    vecs[12] = mk(4'h2, 1, 0, 4'h0, 4'h1, 0, 0, 2'd0, 8'h01, 32'h02030405);
    vecs[13] = mk(4'h2, 0, 0, 4'h2, 4'h0, 0, 1, 2'd1, 8'h11, 32'hBBBB0001);
    vecs[14] = mk(4'h0, 0, 0, 4'h0, 4'h0, 1, 1, 2'd1, 8'h11, 32'hBBBB0001);
    vecs[15] = mk(4'h0, 1, 0, 4'h0, 4'h2, 0, 0, 2'd1, 8'h11, 32'hBBBB0001);
    vecs[16] = mk(4'h8, 0, 0, 4'h8, 4'h0, 0, 1, 2'd3, 8'h33, 32'hDDDD0003);
    vecs[17] = mk(4'h0, 0, 0, 4'h0, 4'h0, 1, 1, 2'd3, 8'h33, 32'hDDDD0003);
    vecs[18] = mk(4'h0, 1, 0, 4'h0, 4'h8, 0, 0, 2'd3, 8'h33, 32'hDDDD0003);
    vecs[19] = mk(4'h4, 0, 1, 4'h0, 4'h0, 0, 0, 2'd3, 8'h33, 32'hDDDD0003);
    vecs[20] = mk(4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 2'd3, 8'h33, 32'hDDDD0003);

    rst_n = 1'b0;
    req_valid = 4'h0;
    req_cmd = {cmds[3], cmds[2], cmds[1], cmds[0]};
    req_data = {datas[3], datas[2], datas[1], datas[0]};
    command_tx_over = 1'b0;
    command_tx_status = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset last_grant", last_grant, 3);
    chk("reset command_tx", command_tx, 0);
    chk("reset data_field_tx", data_field_tx, 0);
    chk("reset pulses", {req_grant, req_done, req_err, command_tx_ready}, 0);
    rst_n = 1'b1;
    step();
    chk("post-reset idle busy", busy, 0);

    // Per-cycle table: drive inputs, clock once, compare every output.
    for (int i = 0; i < 21; i++) begin
      req_valid = vecs[i].valid;
      command_tx_over = vecs[i].over;
      command_tx_status = vecs[i].status;
      step();
      chk($sformatf("v%0d grant", i), req_grant, vecs[i].grant);
      chk($sformatf("v%0d done", i), req_done, vecs[i].done);
      chk($sformatf("v%0d err", i), req_err, 0);
      chk($sformatf("v%0d ready", i), command_tx_ready, vecs[i].ready);
      chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d last_grant", i), last_grant, vecs[i].last);
      chk($sformatf("v%0d command_tx", i), command_tx, vecs[i].cmd);
      chk($sformatf("v%0d data_field_tx", i), data_field_tx, vecs[i].data);
    end
    req_valid = 4'h0;
    command_tx_over = 1'b0;
    command_tx_status = 1'b0;

    // All four requesting continuously: grants rotate 0,1,2,3,0.
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        step();
        if (req_grant != 4'h0) found = 1'b1;
      end
      chk($sformatf("rr%0d grant seen", k), found, 1);
      chk($sformatf("rr%0d grant order", k), req_grant, exp_g);
      chk($sformatf("rr%0d command_tx", k), command_tx, cmds[k % 4]);
      if (k == 4) req_valid = 4'h0;
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
        step();
        if (command_tx_ready) found = 1'b1;
      end
      chk($sformatf("rr%0d ready seen", k), found, 1);
      repeat (8) step();
      command_tx_over = 1'b1;
      step();
      command_tx_over = 1'b0;
      chk($sformatf("rr%0d done", k), req_done, exp_g);
    end

    // Timeout: no completion, err exactly 20 cycles after WAIT_OVER entry.
    req_valid = 4'b0100;
    step();
    chk("to grant", req_grant, 4'b0100);
    req_valid = 4'h0;
    step();
    chk("to ready", command_tx_ready, 1);
    bad = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (req_err !== 4'h0 || req_done !== 4'h0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("to quiet window", bad, 0);
    step();
    chk("to err", req_err, 4'b0100);
    chk("to no done", req_done, 0);
    step();
    chk("to err single pulse", req_err, 0);
    chk("to busy dropped", busy, 0);

    // Completion on the timeout terminal cycle: done wins.
    req_valid = 4'b1000;
    step();
    chk("co grant", req_grant, 4'b1000);
    req_valid = 4'h0;
    step();
    chk("co ready", command_tx_ready, 1);
    bad = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (req_err !== 4'h0 || req_done !== 4'h0) bad = 1'b1;
    end
    chk("co quiet window", bad, 0);
    command_tx_over = 1'b1;
    step();
    command_tx_over = 1'b0;
    chk("co done", req_done, 4'b1000);
    chk("co no err", req_err, 0);
    step();
    chk("co err after", req_err, 0);
    chk("co busy dropped", busy, 0);

    // Reset while waiting for completion abandons the command.
    req_valid = 4'b0001;
    step();
    chk("rs grant", req_grant, 4'b0001);
    req_valid = 4'h0;
    step();
    chk("rs ready", command_tx_ready, 1);
    repeat (3) step();
    chk("rs busy before reset", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs async busy", busy, 0);
    chk("rs async last_grant", last_grant, 3);
    chk("rs async command_tx", command_tx, 0);
    chk("rs async data_field_tx", data_field_tx, 0);
    chk("rs async pulses", {req_grant, req_done, req_err, command_tx_ready}, 0);
    step();
    rst_n = 1'b1;
    command_tx_over = 1'b1;
    step();
    command_tx_over = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (req_done !== 4'h0 || req_err !== 4'h0 || busy !== 1'b0) bad = 1'b1;
      step();
    end
    chk("rs no pulses after release", bad, 0);
    req_valid = 4'b0010;
    step();
    chk("rs fresh grant", req_grant, 4'b0010);
    chk("rs fresh command_tx", command_tx, 8'h11);
    req_valid = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
